onehot_scan_decoder: RTL and testbench
======================================

# onehot_scan_decoder

Parametrised, registered N-to-2^N one-hot decoder for the PWM datapath, successor to the combinational 3-to-8 decoder. It has two modes. In direct mode it decodes an input index with one clock of latency. In scan mode it walks the active output through all 2^N positions, with a programmable dwell per position, a selectable direction, a preload, and a wrap pulse. It drives phase/slot select lines in PWM and multiplexed-output stages.

## Interface
- N, default 3: index width; output width is 2^N (N ≥ 1).
- DWELL_W, default 4: width of the dwell setting.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  block enable; 0 forces out to all-zero.
- mode  in  1  0 = direct decode, 1 = scan.
- in  in  N  index to decode (direct) or preload value (scan).
- load  in  1  scan-mode preload strobe, sampled each cycle.
- dwell  in  DWELL_W  cycles per scan position minus one.
- dir  in  1  scan direction: 0 = increment, 1 = decrement.
- out  out  2^N  registered one-hot output.
- idx  out  N  registered current index.
- wrap  out  1  one-cycle pulse on scan wrap-around.

## Operation
- State registers are idx (N bits), dwell counter cnt (DWELL_W bits), out and wrap. All outputs come straight from registers.
- Reset (rst_n = 0, asynchronous): out = 0, idx = 0, cnt = 0, wrap = 0. These hold until the first rising edge with rst_n = 1.
- Invariant: whenever en was 1 at the last edge, out == 1 << idx. Otherwise out == 0. Exactly one bit is set when enabled.
- en = 0:
  - out <= 0, cnt <= 0, wrap <= 0.
  - idx holds.
  - load, in and mode are ignored.
- Direct mode (en = 1, mode = 0):
  - idx <= in, out <= one-hot(in), cnt <= 0, wrap <= 0.
  - load, dwell and dir are ignored.
- Scan mode (en = 1, mode = 1). Priority order:
  1. load = 1: idx <= in, cnt <= 0, wrap <= 0.
  2. cnt >= dwell (terminal): cnt <= 0. idx <= idx + 1 if dir = 0, idx - 1 if dir = 1, modulo 2^N.
     - wrap <= 1 only when idx goes 2^N-1 -> 0 (dir = 0) or 0 -> 2^N-1 (dir = 1). Otherwise wrap <= 0.
  3. Otherwise: cnt <= cnt + 1, idx holds, wrap <= 0.
  - out <= one-hot of the next idx in all three cases.
- The terminal compare uses >=. If dwell is lowered below the current cnt, the step happens on the next edge; cnt never overruns.
- dwell = 0 steps the index every cycle.
- dir may change at any cycle and takes effect at the next step.
- Mode change:
  - scan -> direct: the next edge loads in.
  - direct -> scan: scanning resumes from the current idx with cnt = 0, which is already the value held in direct mode.
- en 0 -> 1: out shows one-hot of the held idx (direct mode: of in) at the next edge. Scan restarts its dwell from 0.
- Reset asserted mid-scan: all state clears immediately. After release, scanning starts from idx 0.

## Timing
- Direct-mode latency: one clock from in to out/idx.
- Scan period per position: dwell + 1 cycles. Full cycle: 2^N × (dwell + 1) cycles.
- wrap is high for exactly one cycle, the same cycle out first shows the wrapped index.
- load takes effect at the next edge. The loaded position then dwells a full dwell + 1 cycles.
- en falling: out = 0 at the next edge. There is no combinational path from any input to any output.

## Test plan
- Reset/direct: hold rst_n = 0, then release with en = 1, mode = 0, sweep in 0..7 (N = 3) -> out = 0 during reset; afterwards out = 8'h01, 02, …, 80, each one cycle after in, with idx = in.
- Enable gating: direct mode with in = 5, drop en for 3 cycles -> out = 0 starting one edge after en falls, idx holds 5; en back high -> out = 8'h20 at the next edge.
- Scan up with wrap: N = 3, dwell = 2, dir = 0, start at idx 0 -> each bit held 3 cycles in order 01, 02, …, 80, 01; wrap pulses one cycle coincident with the 80 -> 01 transition; 24-cycle period.
- Scan down, dwell = 0: dir = 1, load in = 1 -> out 02, 01, 80, 40 on consecutive cycles; wrap high only on the cycle showing 80.
- Preload and dwell change: dwell = 7 with cnt = 5, then set dwell = 2 -> step on the next edge. Assert load with in = 6 together with a terminal count -> idx = 6, out = 8'h40, no wrap, full dwell restarts.
- Async reset mid-scan: assert rst_n = 0 between edges while out = 8'h10 -> out = 0, idx = 0, wrap = 0 before the next edge; after release, scan restarts from 8'h01.

Source files
------------

// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder
//   Registered N-to-2^N one-hot decoder for phase/slot select lines.
//   Direct mode decodes `in` with one clock of latency. Scan mode walks the
//   active bit through all 2^N positions. Each position is held for
//   dwell+1 cycles, the walk runs in either direction, `in` can be preloaded,
//   and a one-cycle pulse marks wrap-around.
//
//   Operating cases (evaluated at every edge):
//     case              | meaning
//     ------------------+---------------------------------------------------
//     disabled (en=0)   | out/cnt/wrap cleared, idx holds
//     direct  (mode=0)  | idx <= in, cnt cleared
//     scan load         | idx <= in, dwell restarts from 0
//     scan step         | cnt reached dwell: idx +/- 1, wrap on roll-over
//     scan dwell        | cnt counts up, idx holds
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   en     in   block enable, 0 forces out to zero
//   mode   in   0 = direct decode, 1 = scan
//   in     in   [N-1:0] decode index (direct) or preload value (scan)
//   load   in   scan preload strobe
//   dwell  in   [DWELL_W-1:0] cycles per scan position minus one
//   dir    in   scan direction, 0 = up, 1 = down
//   out    out  [2^N-1:0] registered one-hot output
//   idx    out  [N-1:0] registered current index
//   wrap   out  one-cycle pulse when the scan rolls over
module onehot_scan_decoder #(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       in,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               dir,
  output logic [2**N-1:0]    out,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam int W = 2**N;

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_nxt;
  logic [N-1:0]       idx_nxt;
  logic [W-1:0]       out_nxt;
  logic               wrap_nxt;

  always_comb begin
    idx_nxt  = idx;
    cnt_nxt  = '0;
    wrap_nxt = 1'b0;
    out_nxt  = '0;
    if (en) begin
      if (!mode) begin
        idx_nxt = in;
      end else if (load) begin
        idx_nxt = in;
      end else if (cnt >= dwell) begin
        // >= rather than == so a dwell lowered below cnt steps at once
        // instead of letting cnt run all the way round.
        if (dir) begin
          idx_nxt  = idx - 1'b1;
          wrap_nxt = (idx == '0);
        end else begin
          idx_nxt  = idx + 1'b1;
          wrap_nxt = (idx == '1);
        end
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      out_nxt = {{(W-1){1'b0}}, 1'b1} << idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      cnt  <= '0;
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      idx  <= idx_nxt;
      cnt  <= cnt_nxt;
      out  <= out_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
module tb_onehot_scan_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] in;
  logic       load;
  logic [3:0] dwell;
  logic       dir;
  logic [7:0] out;
  logic [2:0] idx;
  logic       wrap;

  int n_cmp;
  int n_err;

  onehot_scan_decoder #(.N(3), .DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .in    (in),
    .load  (load),
    .dwell (dwell),
    .dir   (dir),
    .out   (out),
    .idx   (idx),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [7:0] e_out,
                           input logic [2:0] e_idx, input logic e_wrap);
    // plain compare of the three outputs; each is counted separately
    n_cmp++;
    if (out !== e_out) begin
      n_err++;
      $display("FAIL %s out: got %h expected %h", name, out, e_out);
    end
    n_cmp++;
    if (idx !== e_idx) begin
      n_err++;
      $display("FAIL %s idx: got %0d expected %0d", name, idx, e_idx);
    end
    n_cmp++;
    if (wrap !== e_wrap) begin
      n_err++;
      $display("FAIL %s wrap: got %b expected %b", name, wrap, e_wrap);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; in = 3'd5;
    load = 1'b0; dwell = 4'd0; dir = 1'b0;
    step(); step();
    chk_state("reset_hold", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk_state("reset_release", 8'h00, 3'd0, 1'b0);
  endtask

  task automatic test_direct();
    logic [7:0] e;
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      step();
      e = 8'h01 << i;
      chk_state("direct", e, 3'(i), 1'b0);
    end
  endtask

  task automatic test_enable_gating();
    en = 1'b1; mode = 1'b0; in = 3'd5;
    step();
    chk_state("gate_pre", 8'h20, 3'd5, 1'b0);
    en = 1'b0; in = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("gate_off", 8'h00, 3'd5, 1'b0);
    end
    en = 1'b1; in = 3'd5;
    step();
    chk_state("gate_on", 8'h20, 3'd5, 1'b0);
  endtask

  task automatic test_scan_up();
    logic [2:0] e_idx;
    logic [7:0] e_out;
    en = 1'b1; mode = 1'b0; in = 3'd0;
    step();
    chk_state("scan_up_start", 8'h01, 3'd0, 1'b0);
    mode = 1'b1; dwell = 4'd2; dir = 1'b0; load = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      step();
      e_idx = 3'((k / 3) % 8);
      e_out = 8'h01 << e_idx;
      chk_state("scan_up", e_out, e_idx, (k == 24));
    end
  endtask

  task automatic test_scan_down();
    en = 1'b1; mode = 1'b1; dwell = 4'd0; dir = 1'b1;
    load = 1'b1; in = 3'd1;
    step();
    chk_state("down_load", 8'h02, 3'd1, 1'b0);
    load = 1'b0;
    step();
    chk_state("down_1", 8'h01, 3'd0, 1'b0);
    step();
    chk_state("down_wrap", 8'h80, 3'd7, 1'b1);
    step();
    chk_state("down_3", 8'h40, 3'd6, 1'b0);
  endtask

  task automatic test_preload_dwell();
    en = 1'b1; mode = 1'b1; dir = 1'b0; dwell = 4'd7;
    load = 1'b1; in = 3'd0;
    step();
    chk_state("pre_load0", 8'h01, 3'd0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_state("pre_cnt5", 8'h01, 3'd0, 1'b0);
    dwell = 4'd2;
    step();
    chk_state("dwell_lowered", 8'h02, 3'd1, 1'b0);
    step();
    step();
    chk_state("pre_terminal", 8'h02, 3'd1, 1'b0);
    load = 1'b1; in = 3'd6;
    step();
    chk_state("load_prio", 8'h40, 3'd6, 1'b0);
    load = 1'b0;
    step();
    chk_state("load_dwell1", 8'h40, 3'd6, 1'b0);
    step();
    chk_state("load_dwell2", 8'h40, 3'd6, 1'b0);
    step();
    chk_state("load_step", 8'h80, 3'd7, 1'b0);
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = 1'b1; dir = 1'b0; dwell = 4'd1;
    load = 1'b1; in = 3'd4;
    step();
    chk_state("ar_pre", 8'h10, 3'd4, 1'b0);
    load = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_state("ar_mid", 8'h00, 3'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    chk_state("ar_rest1", 8'h01, 3'd0, 1'b0);
    step();
    chk_state("ar_rest2", 8'h02, 3'd1, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_direct();
    test_enable_gating();
    test_scan_up();
    test_scan_down();
    test_preload_dwell();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
